// File: rtl/add_loa_pipe_if.sv
// add_loa_pipe_if: operand/result handshake bundle
// for the pipelined approximate adder
interface add_loa_pipe_if #(
  parameter int WIDTH = 8,
  parameter int KMAX  = 4
);
  localparam int KW = (KMAX > 0) ? $clog2(KMAX + 1) : 1;

  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [KW-1:0]    K;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH:0]   O;

  modport master (
    output IN_VALID, A, B, K, OUT_READY,
    input  IN_READY, OUT_VALID, O
  );

  modport slave (
    input  IN_VALID, A, B, K, OUT_READY,
    output IN_READY, OUT_VALID, O
  );
endinterface

// File: rtl/add_loa_pipe.sv
// add_loa_pipe: pipelined lower-part-OR adder
// per-beat approximate width, one carry segment per stage
module add_loa_pipe #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4,
  parameter int KMAX  = 4
) (
  input logic           CLK,
  input logic           RST_N,
  add_loa_pipe_if.slave io
);
  localparam int NS = (WIDTH + SEG - 1) / SEG;
  localparam int KW = (KMAX > 0) ? $clog2(KMAX + 1) : 1;

  typedef logic [WIDTH-1:0] word_t;

  logic [NS:0]   v_q;
  logic [NS:0]   adv;
  word_t         a_q   [NS];
  word_t         b_q   [NS];
  logic [KW-1:0] ke_q  [NS];
  word_t         sum_q [NS];
  logic [NS-1:0] c_q;
  word_t         sum_d [NS];
  logic [NS-1:0] c_d;
  word_t         sin   [NS];
  logic [NS-1:0] cin;
  logic [KW-1:0] ke_in;

  assign ke_in = (io.K > KW'(KMAX)) ? KW'(KMAX) : io.K;

  always_comb begin
    logic r;
    adv = '0;
    r = !v_q[NS] || io.OUT_READY;
    adv[NS] = r;
    for (int s = NS - 1; s >= 0; s--) begin
      r = !v_q[s] || r;
      adv[s] = r;
    end
  end

  always_comb begin
    sin[0] = '0;
    cin[0] = 1'b0;
    for (int s = 1; s < NS; s++) begin
      sin[s] = sum_q[s-1];
      cin[s] = c_q[s-1];
    end
  end

  // each bit picks OR or full-add from its own Ke
  always_comb begin
    word_t ps;
    logic  cy;
    int    k;
    ps = '0;
    cy = 1'b0;
    k  = 0;
    for (int s = 0; s < NS; s++) begin
      ps = sin[s];
      cy = cin[s];
      k  = int'(ke_q[s]);
      for (int i = 0; i < WIDTH; i++) begin
        if (i / SEG == s) begin
          if (i < k) begin
            ps[i] = a_q[s][i] | b_q[s][i];
            cy = (i == k - 1) && a_q[s][i] && b_q[s][i];
          end else begin
            ps[i] = a_q[s][i] ^ b_q[s][i] ^ cy;
            cy = (a_q[s][i] & b_q[s][i])
               | (cy & (a_q[s][i] ^ b_q[s][i]));
          end
        end
      end
      sum_d[s] = ps;
      c_d[s]   = cy;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v_q <= '0;
      c_q <= '0;
      for (int s = 0; s < NS; s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        ke_q[s]  <= '0;
        sum_q[s] <= '0;
      end
    end else begin
      if (adv[0]) v_q[0] <= io.IN_VALID;
      if (adv[0] && io.IN_VALID) begin
        a_q[0]  <= io.A;
        b_q[0]  <= io.B;
        ke_q[0] <= ke_in;
      end
      for (int s = 0; s < NS; s++) begin
        if (adv[s+1]) v_q[s+1] <= v_q[s];
        if (adv[s+1] && v_q[s]) begin
          sum_q[s] <= sum_d[s];
          c_q[s]   <= c_d[s];
        end
      end
      for (int s = 1; s < NS; s++) begin
        if (adv[s] && v_q[s-1]) begin
          a_q[s]  <= a_q[s-1];
          b_q[s]  <= b_q[s-1];
          ke_q[s] <= ke_q[s-1];
        end
      end
    end
  end

  assign io.IN_READY  = adv[0];
  assign io.OUT_VALID = v_q[NS];
  assign io.O         = {c_q[NS-1], sum_q[NS-1]};
endmodule

// File: tb/tb_add_loa_pipe.sv
// tb_add_loa_pipe: directed checks on an 8-bit instance
// plus a 16-bit instance against a behavioural reference
module tb_add_loa_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  add_loa_pipe_if #(.WIDTH(8), .KMAX(4)) u8 ();
  add_loa_pipe_if #(.WIDTH(16), .KMAX(16)) u16 ();

  add_loa_pipe #(.WIDTH(8), .SEG(4), .KMAX(4)) dut8 (
    .CLK(clk), .RST_N(rst_n), .io(u8.slave)
  );
  add_loa_pipe #(.WIDTH(16), .SEG(5), .KMAX(16)) dut16 (
    .CLK(clk), .RST_N(rst_n), .io(u16.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref16(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input int k);
    int ke;
    logic [31:0] mask, lo, hi, c;
    ke   = (k > 16) ? 16 : k;
    mask = (32'd1 << ke) - 32'd1;
    lo   = 32'(a | b) & mask;
    c    = 32'd0;
    if (ke > 0) c = ((32'(a) >> (ke - 1)) & (32'(b) >> (ke - 1))) & 32'd1;
    hi   = (32'(a) >> ke) + (32'(b) >> ke) + c;
    return (hi << ke) | lo;
  endfunction

  initial begin
    logic [31:0] q[$];
    logic [7:0]  sa [6];
    logic [7:0]  sb [6];
    logic [31:0] e;
    int sent, got, stall;
    bit seen, drop;

    rst_n = 1'b0;
    u8.IN_VALID = 0; u8.A = 0; u8.B = 0; u8.K = 0; u8.OUT_READY = 1;
    u16.IN_VALID = 0; u16.A = 0; u16.B = 0; u16.K = 0; u16.OUT_READY = 1;
    repeat (2) tick;
    chk("rst_ov", u8.OUT_VALID, 0);
    chk("rst_o", u8.O, 0);
    chk("rst_ov16", u16.OUT_VALID, 0);
    rst_n = 1'b1;
    tick;
    chk("rst_ir", u8.IN_READY, 1);

    // exact sum, latency 2
    u8.IN_VALID = 1; u8.A = 200; u8.B = 100; u8.K = 0;
    tick;
    u8.IN_VALID = 0;
    chk("t1_ir", u8.IN_READY, 1);
    tick;
    chk("t1_lat", u8.OUT_VALID, 0);
    tick;
    chk("t1_ov", u8.OUT_VALID, 1);
    chk("t1_o", u8.O, 32'h12C);
    chk("t1_ir2", u8.IN_READY, 1);
    tick;
    chk("t1_pop", u8.OUT_VALID, 0);
    chk("t1_hold", u8.O, 32'h12C);

    // back-to-back K=2
    u8.IN_VALID = 1; u8.A = 3; u8.B = 3; u8.K = 2;
    tick;
    u8.A = 3; u8.B = 1; u8.K = 2;
    tick;
    u8.IN_VALID = 0;
    tick;
    chk("t2_ov0", u8.OUT_VALID, 1);
    chk("t2_o0", u8.O, 32'h007);
    tick;
    chk("t2_ov1", u8.OUT_VALID, 1);
    chk("t2_o1", u8.O, 32'h003);
    tick;
    chk("t2_end", u8.OUT_VALID, 0);

    // clamped K vs exact on same operands
    u8.IN_VALID = 1; u8.A = 8'hFF; u8.B = 8'h01; u8.K = 7;
    tick;
    u8.K = 0;
    tick;
    u8.IN_VALID = 0;
    tick;
    chk("t3_clamp", u8.O, 32'h0FF);
    tick;
    chk("t3_exact", u8.O, 32'h100);
    chk("t3_ov", u8.OUT_VALID, 1);
    tick;

    // stream 6 with a 3-cycle stall after first result
    for (int i = 0; i < 6; i++) begin
      sa[i] = 8'(i * 37 + 5);
      sb[i] = 8'(i * 23 + 200);
    end
    sent = 0; got = 0; stall = 0; seen = 0; drop = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      u8.IN_VALID = (sent < 6);
      if (sent < 6) begin
        u8.A = sa[sent]; u8.B = sb[sent]; u8.K = 0;
      end
      u8.OUT_READY = (stall == 0);
      #1;
      if (!u8.IN_READY) drop = 1;
      if (u8.OUT_VALID) begin
        e = 32'(sa[got]) + 32'(sb[got]);
        chk("t4_o", u8.O, e);
        if (u8.OUT_READY) begin
          got++;
          if (!seen) begin seen = 1; stall = 3; end
        end else begin
          stall--;
        end
      end
      if (u8.IN_VALID && u8.IN_READY) sent++;
      tick;
    end
    u8.IN_VALID = 0; u8.OUT_READY = 1;
    chk("t4_got", got, 6);
    chk("t4_sent", sent, 6);
    chk("t4_backpressure", drop, 1);
    chk("t4_nodup", u8.OUT_VALID, 0);

    // reset with beats in flight
    u8.IN_VALID = 1; u8.A = 5; u8.B = 6; u8.K = 0;
    tick;
    u8.A = 7; u8.B = 8;
    tick;
    u8.IN_VALID = 0;
    tick;
    chk("t5_pre_ov", u8.OUT_VALID, 1);
    chk("t5_pre_o", u8.O, 11);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ov", u8.OUT_VALID, 0);
    chk("t5_rst_o", u8.O, 0);
    tick;
    rst_n = 1'b1;
    tick;
    u8.IN_VALID = 1; u8.A = 1; u8.B = 1; u8.K = 0;
    tick;
    u8.IN_VALID = 0;
    chk("t5_stale0", u8.OUT_VALID, 0);
    tick;
    chk("t5_stale1", u8.OUT_VALID, 0);
    tick;
    chk("t5_ov", u8.OUT_VALID, 1);
    chk("t5_o", u8.O, 2);
    tick;

    // 16-bit: K=16 all-OR, latency 4
    u16.IN_VALID = 1; u16.A = 16'h8000; u16.B = 16'h8000; u16.K = 16;
    tick;
    u16.IN_VALID = 0;
    tick; tick; tick;
    chk("w16_lat", u16.OUT_VALID, 0);
    tick;
    chk("w16_ov", u16.OUT_VALID, 1);
    chk("w16_k16", u16.O, 32'h18000);
    tick;

    // 16-bit random traffic
    for (int cyc = 0; cyc < 600; cyc++) begin
      u16.IN_VALID  = 1'($urandom_range(0, 1));
      u16.A         = 16'($urandom);
      u16.B         = 16'($urandom);
      u16.K         = 5'($urandom_range(0, 31));
      u16.OUT_READY = ($urandom_range(0, 3) != 0);
      #1;
      if (u16.OUT_VALID && u16.OUT_READY) begin
        if (q.size() == 0) chk("r_extra", u16.OUT_VALID, 0);
        else begin
          e = q.pop_front();
          chk("r_o", u16.O, e);
        end
      end
      if (u16.IN_VALID && u16.IN_READY)
        q.push_back(ref16(u16.A, u16.B, int'(u16.K)));
      tick;
    end
    u16.IN_VALID = 0; u16.OUT_READY = 1;
    for (int cyc = 0; cyc < 20 && q.size() > 0; cyc++) begin
      #1;
      if (u16.OUT_VALID) begin
        e = q.pop_front();
        chk("r_drain_o", u16.O, e);
      end
      tick;
    end
    chk("r_drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
